// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - single-port memory bus between the arbiter (master) and memory (slave)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [SEL_W-1:0]  bus_sel_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between instruction fetch and data access
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  mem_bus_arbiter_if.master bus,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  output logic              bus_err_o,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o
);
  typedef enum logic [2:0] {
    IDLE, BUSY_MEM, BUSY_IF, BUSY_IF_DROP, RESP_MEM, RESP_IF
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              err_q, err_d;
  logic              ack;
  logic              timeout;

  assign ack     = bus.bus_ack_i;
  assign timeout = !ack && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          req_d   = 1'b1;
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          sel_d   = mem_sel_i;
          cnt_d   = '0;
          state_d = BUSY_MEM;
        end else if (if_req_i && !flush_i) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          sel_d   = '1;
          cnt_d   = '0;
          state_d = BUSY_IF;
        end
      end
      BUSY_MEM: begin
        cnt_d = cnt_q + 8'd1;
        if (ack) begin
          req_d       = 1'b0;
          mem_rdata_d = bus.bus_rdata_i;
          state_d     = RESP_MEM;
        end else if (timeout) begin
          req_d       = 1'b0;
          mem_rdata_d = '0;
          err_d       = 1'b1;
          state_d     = RESP_MEM;
        end
      end
      BUSY_IF: begin
        cnt_d = cnt_q + 8'd1;
        // A flush landing on the completing cycle simply discards the result.
        if (flush_i) begin
          if (ack || timeout) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = BUSY_IF_DROP;
          end
        end else if (ack) begin
          req_d      = 1'b0;
          if_rdata_d = bus.bus_rdata_i;
          state_d    = RESP_IF;
        end else if (timeout) begin
          req_d      = 1'b0;
          if_rdata_d = '0;
          err_d      = 1'b1;
          state_d    = RESP_IF;
        end
      end
      BUSY_IF_DROP: begin
        cnt_d = cnt_q + 8'd1;
        if (ack || timeout) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      RESP_MEM, RESP_IF: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;
  assign bus.bus_sel_o   = sel_q;

  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign if_done_o      = (state_q == RESP_IF) && !flush_i;
  assign mem_done_o     = (state_q == RESP_MEM);
  assign bus_err_o      = err_q && !((state_q == RESP_IF) && flush_i);
  assign stallreq_if_o  = if_req_i && !if_done_o;
  assign stallreq_mem_o = mem_req_i && !mem_done_o;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with directed and random traffic
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i, flush_i, mem_req_i, mem_we_i;
  logic [AW-1:0] if_addr_i, mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [SW-1:0] mem_sel_i;
  logic [DW-1:0] if_rdata_o, mem_rdata_o;
  logic          if_done_o, mem_done_o, bus_err_o, stallreq_if_o, stallreq_mem_o;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
    .bus(bus),
    .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .bus_err_o(bus_err_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];

  logic [31:0] cur_if_addr, cur_mem_addr, cur_mem_wdata;
  logic [3:0]  cur_mem_sel;
  logic        cur_mem_we;

  // Memory contents are a fixed function of address; address bits [6:4] give the ack delay.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h2402_0005;
  endfunction

  function automatic logic times_out(input logic [31:0] a);
    return int'(a[6:4]) >= TO;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no matching event, want one", name);
  endtask

  task automatic set_mem(input logic [31:0] a, input logic we, input logic [3:0] sel);
    exp_t e;
    e.err = times_out(a);
    e.data = e.err ? 32'h0 : rd_word(a);
    e.chk = !we || e.err;
    mem_q.push_back(e);
    cur_mem_addr  = a;
    cur_mem_we    = we;
    cur_mem_sel   = sel;
    cur_mem_wdata = a ^ 32'hDEAD_BEEF;
    mem_addr_i    = a;
    mem_we_i      = we;
    mem_sel_i     = sel;
    mem_wdata_i   = cur_mem_wdata;
    mem_req_i     = 1'b1;
  endtask

  task automatic set_if(input logic [31:0] a);
    exp_t e;
    e.err = times_out(a);
    e.data = e.err ? 32'h0 : rd_word(a);
    e.chk = 1'b1;
    if_q.push_back(e);
    cur_if_addr = a;
    if_addr_i   = a;
    if_req_i    = 1'b1;
  endtask

  task automatic wait_mem_done(output int dc);
    dc = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_done_o) begin
        dc = cyc;
        break;
      end
    end
    mem_req_i = 1'b0;
    if (dc < 0) begin
      fail("mem_done_wait");
      mem_q.delete();
    end
  endtask

  task automatic if_xfer(input logic [31:0] a);
    bit got, flushed;
    got = 0;
    flushed = 0;
    set_if(a);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (if_done_o) begin
        got = 1;
        break;
      end else if ($urandom_range(0, 11) == 0) begin
        flush_i = 1'b1;
        void'(if_q.pop_front());
        flushed = 1;
        @(negedge clk);
        flush_i = 1'b0;
        break;
      end
    end
    if_req_i = 1'b0;
    if (!got && !flushed) begin
      fail("if_done_wait");
      if_q.delete();
    end
  endtask

  // Memory responder: acks after the delay encoded in the granted address.
  int          rsp_cnt = 0;
  logic        rsp_on = 1'b0;
  logic [31:0] rsp_addr;
  always @(posedge clk or negedge rst) begin
    #1;
    if (bus.bus_req_o) begin
      if (!rsp_on) begin
        rsp_on   = 1'b1;
        rsp_cnt  = 0;
        rsp_addr = bus.bus_addr_o;
        if (rsp_addr[31]) begin
          check32("grant_mem_addr", bus.bus_addr_o, cur_mem_addr);
          check1("grant_mem_we", bus.bus_we_o, cur_mem_we);
          check32("grant_mem_sel", 32'(bus.bus_sel_o), 32'(cur_mem_sel));
          if (cur_mem_we) check32("grant_mem_wdata", bus.bus_wdata_o, cur_mem_wdata);
        end else begin
          check32("grant_if_addr", bus.bus_addr_o, cur_if_addr);
          check1("grant_if_we", bus.bus_we_o, 1'b0);
          check32("grant_if_sel", 32'(bus.bus_sel_o), 32'hF);
        end
      end else begin
        rsp_cnt++;
        check32("bus_addr_stable", bus.bus_addr_o, rsp_addr);
      end
      bus.bus_ack_i   = (rsp_cnt == int'(rsp_addr[6:4]));
      bus.bus_rdata_i = bus.bus_ack_i ? rd_word(rsp_addr) : $urandom;
    end else begin
      rsp_on          = 1'b0;
      bus.bus_ack_i   = 1'b0;
      bus.bus_rdata_i = $urandom;
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (mem_done_o) begin
        if (mem_q.size() == 0) fail("mem_done_unexpected");
        else begin
          mon_e = mem_q.pop_front();
          check1("mem_err", bus_err_o, mon_e.err);
          if (mon_e.chk) check32("mem_rdata", mem_rdata_o, mon_e.data);
        end
      end
      if (if_done_o) begin
        if (if_q.size() == 0) fail("if_done_unexpected");
        else begin
          mon_e = if_q.pop_front();
          check1("if_err", bus_err_o, mon_e.err);
          check32("if_rdata", if_rdata_o, mon_e.data);
        end
      end
      if (!mem_done_o && !if_done_o && bus_err_o) fail("err_without_done");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want one");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, d0, d1;
    if_req_i = 0; flush_i = 0; mem_req_i = 0; mem_we_i = 0;
    if_addr_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0;
    cur_if_addr = 0; cur_mem_addr = 0; cur_mem_wdata = 0; cur_mem_sel = 0; cur_mem_we = 0;
    repeat (3) @(negedge clk);
    check1("rst_bus_req", bus.bus_req_o, 1'b0);
    check32("rst_bus_addr", bus.bus_addr_o, 32'h0);
    check1("rst_if_done", if_done_o, 1'b0);
    check1("rst_mem_done", mem_done_o, 1'b0);
    check1("rst_bus_err", bus_err_o, 1'b0);
    check32("rst_if_rdata", if_rdata_o, 32'h0);
    check32("rst_mem_rdata", mem_rdata_o, 32'h0);
    rst = 1'b1;

    // IF alone, zero-wait ack
    @(negedge clk); set_if(32'h0000_0100);
    #1;
    check1("t1_stall_c0", stallreq_if_o, 1'b1);
    check1("t1_req_c0", bus.bus_req_o, 1'b0);
    @(negedge clk);
    check1("t1_req_c1", bus.bus_req_o, 1'b1);
    check32("t1_addr_c1", bus.bus_addr_o, 32'h100);
    check1("t1_stall_c1", stallreq_if_o, 1'b1);
    @(negedge clk);
    check1("t1_done_c2", if_done_o, 1'b1);
    check1("t1_stall_c2", stallreq_if_o, 1'b0);
    check1("t1_req_c2", bus.bus_req_o, 1'b0);
    if_req_i = 0;

    // MEM and IF together: MEM first
    @(negedge clk); set_mem(32'h8000_0200, 1'b1, 4'hF); set_if(32'h0000_0300);
    @(negedge clk);
    check1("t2_we_c1", bus.bus_we_o, 1'b1);
    check32("t2_addr_c1", bus.bus_addr_o, 32'h8000_0200);
    check1("t2_stall_if_c1", stallreq_if_o, 1'b1);
    @(negedge clk);
    check1("t2_mem_done_c2", mem_done_o, 1'b1);
    check1("t2_stall_mem_c2", stallreq_mem_o, 1'b0);
    check1("t2_stall_if_c2", stallreq_if_o, 1'b1);
    mem_req_i = 0;
    @(negedge clk);
    check1("t2_idle_c3", bus.bus_req_o, 1'b0);
    check1("t2_stall_if_c3", stallreq_if_o, 1'b1);
    @(negedge clk);
    check1("t2_if_req_c4", bus.bus_req_o, 1'b1);
    check32("t2_if_addr_c4", bus.bus_addr_o, 32'h300);
    check1("t2_if_we_c4", bus.bus_we_o, 1'b0);
    @(negedge clk);
    check1("t2_if_done_c5", if_done_o, 1'b1);
    if_req_i = 0;

    // Flush during BUSY_IF, ack arrives later and is swallowed
    @(negedge clk); set_if(32'h0000_0420);
    @(negedge clk);
    check1("t3_busy_c1", bus.bus_req_o, 1'b1);
    flush_i = 1; void'(if_q.pop_front());
    @(negedge clk);
    flush_i = 0; if_req_i = 0;
    check1("t3_drop_req_c2", bus.bus_req_o, 1'b1);
    check1("t3_no_done_c2", if_done_o, 1'b0);
    @(negedge clk);
    check1("t3_drop_req_c3", bus.bus_req_o, 1'b1);
    check1("t3_no_done_c3", if_done_o, 1'b0);
    @(negedge clk);
    check1("t3_idle_c4", bus.bus_req_o, 1'b0);
    check1("t3_no_done_c4", if_done_o, 1'b0);
    set_if(32'h0000_0300);
    @(negedge clk);
    check1("t3_regrant_c5", bus.bus_req_o, 1'b1);
    check32("t3_regrant_addr", bus.bus_addr_o, 32'h300);
    @(negedge clk);
    check1("t3_done_c6", if_done_o, 1'b1);
    if_req_i = 0;

    // Timeout on a MEM load
    @(negedge clk); set_mem(32'h8000_0460, 1'b0, 4'hF);
    hi = 0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      if (bus.bus_req_o) hi++;
    end
    check32("t4_busy_cycles", 32'(hi), 32'(TO));
    @(negedge clk);
    check1("t4_req_dropped", bus.bus_req_o, 1'b0);
    check1("t4_done", mem_done_o, 1'b1);
    check1("t4_err", bus_err_o, 1'b1);
    mem_req_i = 0;

    // Asynchronous reset during BUSY_MEM, held request re-granted
    @(negedge clk); set_mem(32'h8000_0070, 1'b0, 4'h3);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check1("t5_rst_req", bus.bus_req_o, 1'b0);
    check32("t5_rst_addr", bus.bus_addr_o, 32'h0);
    check32("t5_rst_if_rdata", if_rdata_o, 32'h0);
    check1("t5_rst_done", mem_done_o, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check1("t5_regrant", bus.bus_req_o, 1'b1);
    wait_mem_done(d0);

    // Back-to-back zero-wait MEM loads
    @(negedge clk);
    set_mem(32'h8000_0008, 1'b0, 4'hF); wait_mem_done(d0);
    set_mem(32'h8000_000C, 1'b0, 4'hF); wait_mem_done(d1);
    check32("t6_done_spacing", 32'(d1 - d0), 32'd3);

    // Random concurrent traffic
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int dm;
          repeat ($urandom_range(2, 5)) @(negedge clk);
          set_mem({1'b1, 24'($urandom), 3'($urandom_range(0, 7)), 4'h0},
                  1'($urandom_range(0, 1)), 4'($urandom));
          wait_mem_done(dm);
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if_xfer({1'b0, 24'($urandom), 3'($urandom_range(0, 7)), 4'h0});
        end
      end
    join
    repeat (20) @(negedge clk);
    check32("sb_drain", 32'(if_q.size() + mem_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
